// File: rtl/audio_frame_packer_if.sv
// Byte-stream input, sample-FIFO output and statistics bundle for audio_frame_packer.
// slave = packer side, master = byte source / sample sink side.
interface audio_frame_packer_if;
    logic        byte_wr_en_i;
    logic [7:0]  byte_data_i;
    logic        byte_full_o;
    logic        byte_afull_o;
    logic        sample_wr_en_o;
    logic [47:0] sample_data_o;
    logic        sample_full_i;
    logic        sample_afull_i;
    logic        overflow_o;
    logic [15:0] frame_cnt_o;
    logic [15:0] err_cnt_o;

    modport slave (
        input  byte_wr_en_i, byte_data_i, sample_full_i, sample_afull_i,
        output byte_full_o, byte_afull_o, sample_wr_en_o, sample_data_o,
               overflow_o, frame_cnt_o, err_cnt_o
    );

    modport master (
        output byte_wr_en_i, byte_data_i, sample_full_i, sample_afull_i,
        input  byte_full_o, byte_afull_o, sample_wr_en_o, sample_data_o,
               overflow_o, frame_cnt_o, err_cnt_o
    );
endinterface

// File: rtl/audio_frame_packer.sv
// Packs SYNC,L0..L2,R0..R2,CSUM byte frames into 48-bit samples; AUDIO_PACKER_STATS_EN builds counters.
// Latency: CSUM byte popped at cycle M -> sample write strobe at M+1; bytes sit >= 1 cycle in a 2-entry skid.
// Backpressure: holds a checked frame while the sample FIFO is full/afull; byte_afull_o throttles upstream.
module audio_frame_packer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                 fifo_clk_i,
    input  logic                 reset_i,
    audio_frame_packer_if.slave  bus
);
    typedef enum logic [1:0] {HUNT, DATA, CSUM, COMMIT} state_t;

    state_t          state, state_nxt;
    logic [2:0]      idx, idx_nxt;
    logic [7:0]      skid_mem [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      count;
    logic            push, pop;
    logic [7:0]      pop_dat;
    logic [5:0][7:0] frame_reg;
    logic [7:0]      csum_acc;
    logic [47:0]     last_dat;
    logic            frame_pending;
    logic            commit;
    logic            overflow;

    assign frame_pending    = (state == COMMIT);
    assign bus.byte_full_o  = (count == 2'd2);
    assign bus.byte_afull_o = (count != 2'd0) || frame_pending;
    assign push             = bus.byte_wr_en_i && !bus.byte_full_o;
    assign pop              = (state != COMMIT) && (count != 2'd0);
    assign pop_dat          = skid_mem[rd_ptr];

    always_ff @(posedge fifo_clk_i or posedge reset_i) begin
        if (reset_i) begin
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                skid_mem[wr_ptr] <= bus.byte_data_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        commit    = 1'b0;
        case (state)
            HUNT: begin
                if (pop && (pop_dat == SYNC_BYTE)) begin
                    state_nxt = DATA;
                    idx_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (pop) begin
                    if (idx == 3'd5) state_nxt = CSUM;
                    else             idx_nxt   = idx + 3'd1;
                end
            end
            CSUM: begin
                if (pop) state_nxt = (pop_dat == csum_acc) ? COMMIT : HUNT;
            end
            COMMIT: begin
                if (!bus.sample_full_i && !bus.sample_afull_i) begin
                    commit    = 1'b1;
                    state_nxt = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge fifo_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= HUNT;
            idx       <= 3'd0;
            frame_reg <= '0;
            csum_acc  <= 8'd0;
            last_dat  <= 48'd0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if ((state == DATA) && pop) begin
                for (int i = 0; i < 6; i++) begin
                    if (idx == i[2:0]) frame_reg[i] <= pop_dat;
                end
                csum_acc <= (idx == 3'd0) ? pop_dat : (csum_acc ^ pop_dat);
            end
            if (commit) last_dat <= frame_reg;
            if (bus.byte_wr_en_i && bus.byte_full_o) overflow <= 1'b1;
        end
    end

    // The pending frame is only presented during its strobe so the output keeps the last written sample otherwise.
    assign bus.sample_wr_en_o = commit;
    assign bus.sample_data_o  = commit ? frame_reg : last_dat;
    assign bus.overflow_o     = overflow;

`ifdef AUDIO_PACKER_STATS_EN
    logic [15:0] frame_cnt, err_cnt;
    logic        err_evt;

    assign err_evt = pop && (((state == HUNT) && (pop_dat != SYNC_BYTE)) ||
                             ((state == CSUM) && (pop_dat != csum_acc)));

    always_ff @(posedge fifo_clk_i or posedge reset_i) begin
        if (reset_i) begin
            frame_cnt <= 16'd0;
            err_cnt   <= 16'd0;
        end else begin
            if (commit && (frame_cnt != 16'hFFFF)) frame_cnt <= frame_cnt + 16'd1;
            if (err_evt && (err_cnt != 16'hFFFF))  err_cnt   <= err_cnt + 16'd1;
        end
    end

    assign bus.frame_cnt_o = frame_cnt;
    assign bus.err_cnt_o   = err_cnt;
`else
    assign bus.frame_cnt_o = 16'd0;
    assign bus.err_cnt_o   = 16'd0;
`endif
endmodule

// File: tb/tb_audio_frame_packer.sv
// Directed table-driven bench for audio_frame_packer plus hand-written backpressure/overflow/reset sequences.
module tb_audio_frame_packer;
`ifdef AUDIO_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [47:0] F1 = 48'h060504_030201;
    localparam logic [47:0] F2 = 48'h665544_332211;
    localparam logic [47:0] F3 = 48'h605040_302010;

    typedef struct {
        logic        we;
        logic [7:0]  d;
        logic        e_stb;
        logic        e_afull;
        logic        e_full;
        logic [47:0] e_dat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   stb_cnt = 0;
    int   base;
    vec_t vt[$];

    audio_frame_packer_if bus();

    audio_frame_packer #(.SYNC_BYTE(8'hA5)) dut (
        .fifo_clk_i (clk),
        .reset_i    (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.sample_wr_en_o === 1'b1) stb_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic we, input logic [7:0] d, input logic stb, input logic af,
                       input logic [47:0] dat);
        vt.push_back('{we: we, d: d, e_stb: stb, e_afull: af, e_full: 1'b0, e_dat: dat});
    endtask

    // Eight back-to-back pushes, then the drain cycles; b holds SYNC in its top byte.
    task automatic add_frame(input logic [63:0] b, input logic lead_af, input logic good,
                             input logic [47:0] prev, input logic [47:0] nxt);
        for (int i = 0; i < 8; i++) add(1'b1, b[63-8*i -: 8], 1'b0, (i != 0) || lead_af, prev);
        add(1'b0, 8'h00, 1'b0, 1'b1, prev);
        if (good) begin
            add(1'b0, 8'h00, 1'b1, 1'b1, nxt);
            add(1'b0, 8'h00, 1'b0, 1'b0, nxt);
        end else begin
            add(1'b0, 8'h00, 1'b0, 1'b0, prev);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (bus.byte_full_o === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL send_wait: byte_full stuck got 1 expected 0");
        end
        bus.byte_wr_en_i = 1'b1;
        bus.byte_data_i  = b;
        @(posedge clk); #1;
        bus.byte_wr_en_i = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] b);
        for (int i = 0; i < 8; i++) send(b[63-8*i -: 8]);
    endtask

    task automatic wait_stb(input int target);
        int n = 0;
        while (stb_cnt < target && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("strobe_arrived", 64'(stb_cnt >= target), 64'd1);
    endtask

    initial begin
        bus.byte_wr_en_i   = 1'b0;
        bus.byte_data_i    = 8'h00;
        bus.sample_full_i  = 1'b0;
        bus.sample_afull_i = 1'b0;

        add_frame(64'hA5_01_02_03_04_05_06_07, 1'b0, 1'b1, 48'd0, F1);
        add(1'b1, 8'h00, 1'b0, 1'b0, F1);
        add(1'b1, 8'h11, 1'b0, 1'b1, F1);
        add_frame(64'hA5_11_22_33_44_55_66_77, 1'b1, 1'b1, F1, F2);
        add_frame(64'hA5_01_02_03_04_05_06_FF, 1'b0, 1'b0, F2, F2);
        add_frame(64'hA5_10_20_30_40_50_60_70, 1'b0, 1'b1, F2, F3);

        @(negedge clk);
        chk("rst_stb",   64'(bus.sample_wr_en_o), 64'd0);
        chk("rst_data",  64'(bus.sample_data_o),  64'd0);
        chk("rst_flags", 64'({bus.byte_full_o, bus.byte_afull_o, bus.overflow_o}), 64'd0);
        chk("rst_cnts",  64'({bus.frame_cnt_o, bus.err_cnt_o}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            bus.byte_wr_en_i = vt[i].we;
            bus.byte_data_i  = vt[i].d;
            @(negedge clk);
            n_vec++;
            if (bus.sample_wr_en_o !== vt[i].e_stb || bus.byte_afull_o !== vt[i].e_afull ||
                bus.byte_full_o !== vt[i].e_full || bus.sample_data_o !== vt[i].e_dat) begin
                n_err++;
                $display("FAIL vec[%0d] stb/afull/full/data: got %b/%b/%b/%h expected %b/%b/%b/%h",
                         i, bus.sample_wr_en_o, bus.byte_afull_o, bus.byte_full_o, bus.sample_data_o,
                         vt[i].e_stb, vt[i].e_afull, vt[i].e_full, vt[i].e_dat);
            end
            @(posedge clk); #1;
        end
        bus.byte_wr_en_i = 1'b0;
        chk("tbl_frame_cnt", 64'(bus.frame_cnt_o), STATS ? 64'd3 : 64'd0);
        chk("tbl_err_cnt",   64'(bus.err_cnt_o),   STATS ? 64'd3 : 64'd0);
        chk("tbl_overflow",  64'(bus.overflow_o),  64'd0);

        // Sample FIFO almost-full held across a committed frame, then full, then released.
        bus.sample_afull_i = 1'b1;
        base = stb_cnt;
        send_frame(64'hA5_01_02_03_04_05_06_07);
        repeat (21) @(negedge clk);
        chk("bp_no_strobe", 64'(stb_cnt - base), 64'd0);
        chk("bp_afull",     64'(bus.byte_afull_o), 64'd1);
        chk("bp_data_held", 64'(bus.sample_data_o), 64'(F3));
        @(posedge clk); #1;
        bus.sample_afull_i = 1'b0;
        bus.sample_full_i  = 1'b1;
        @(negedge clk);
        chk("bp_full_blocks", 64'(bus.sample_wr_en_o), 64'd0);
        @(posedge clk); #1;
        bus.sample_full_i = 1'b0;
        @(negedge clk);
        chk("bp_release_stb",  64'(bus.sample_wr_en_o), 64'd1);
        chk("bp_release_data", 64'(bus.sample_data_o), 64'(F1));
        @(posedge clk); #1;

        // Pending frame stalls popping; third push hits a full skid and is dropped.
        bus.sample_afull_i = 1'b1;
        send_frame(64'hA5_11_22_33_44_55_66_77);
        @(posedge clk); #1;
        send(8'hA5);
        send(8'h01);
        chk("ovf_full",   64'(bus.byte_full_o), 64'd1);
        chk("ovf_before", 64'(bus.overflow_o),  64'd0);
        bus.byte_wr_en_i = 1'b1;
        bus.byte_data_i  = 8'h99;
        @(posedge clk); #1;
        bus.byte_wr_en_i = 1'b0;
        chk("ovf_set",       64'(bus.overflow_o),  64'd1);
        chk("ovf_full_hold", 64'(bus.byte_full_o), 64'd1);
        base = stb_cnt;
        bus.sample_afull_i = 1'b0;
        @(negedge clk);
        chk("ovf_pending_data", 64'(bus.sample_data_o), 64'(F2));
        @(posedge clk); #1;
        send(8'h02); send(8'h03); send(8'h04); send(8'h05); send(8'h06); send(8'h07);
        wait_stb(base + 2);
        chk("ovf_next_frame", 64'(bus.sample_data_o), 64'(F1));
        chk("ovf_sticky",     64'(bus.overflow_o),    64'd1);

        // Reset after L1 discards the partial frame and clears everything.
        @(posedge clk); #1;
        send(8'hA5); send(8'h01); send(8'h02);
        rst = 1'b1;
        #2;
        chk("mid_rst_stb",   64'(bus.sample_wr_en_o), 64'd0);
        chk("mid_rst_data",  64'(bus.sample_data_o),  64'd0);
        chk("mid_rst_flags", 64'({bus.byte_full_o, bus.byte_afull_o, bus.overflow_o}), 64'd0);
        chk("mid_rst_cnts",  64'({bus.frame_cnt_o, bus.err_cnt_o}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        base = stb_cnt;
        send(8'h03); send(8'h04); send(8'h05); send(8'h06); send(8'h07);
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_stb", 64'(stb_cnt - base), 64'd0);
        chk("post_rst_err",    64'(bus.err_cnt_o), STATS ? 64'd5 : 64'd0);
        send_frame(64'hA5_10_20_30_40_50_60_70);
        wait_stb(base + 1);
        chk("post_rst_data", 64'(bus.sample_data_o), 64'(F3));
        @(posedge clk); #1;
        chk("post_rst_frame_cnt", 64'(bus.frame_cnt_o), STATS ? 64'd1 : 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
